// File: rtl/ise_sorter_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ise_pkg (package)
//  Purpose : Shared types and helpers for the image sorting engine:
//            colour codes, FSM state encoding, width helpers and the
//            per-pixel dominant-colour classification.
//  Rev     : 1.0  initial release
// ============================================================================
package ise_pkg;

  typedef enum logic [1:0] {
    COL_R    = 2'd0,
    COL_G    = 2'd1,
    COL_B    = 2'd2,
    COL_IDLE = 2'd3
  } color_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CLASS  = 3'd2,
    ST_DIV    = 3'd3,
    ST_INSERT = 3'd4,
    ST_OUT    = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  // Widest channel the classifier accepts; callers zero-extend to this.
  localparam int CLS_MAX_W = 16;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // Width of the fixed-point average.
  function automatic int q_width(input int pix_w, input int frac_w);
    return pix_w + frac_w;
  endfunction

  // R wins all ties it participates in; G beats B on a tie.
  function automatic color_t pixel_class(input logic [CLS_MAX_W-1:0] r,
                                         input logic [CLS_MAX_W-1:0] g,
                                         input logic [CLS_MAX_W-1:0] b);
    if (r >= g && r >= b) return COL_R;
    else if (g >= b)      return COL_G;
    else                  return COL_B;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ise_sorter_div.sv
`default_nettype none
// ============================================================================
//  Module  : ise_div
//  Purpose : Restoring unsigned divider with a fixed Q_W+1 cycle latency.
//            The caller guarantees the quotient fits in Q_W bits, so the
//            upper DVD_W-Q_W dividend bits are already smaller than the
//            divisor and seed the partial remainder directly.
//  Ports   : clk, reset (async, active-high)
//            start    - 1-cycle pulse, loads dividend
//            dividend - DVD_W bits, divisor - DVS_W bits (held during run)
//            done     - 1-cycle pulse when quotient is valid
//            quotient - Q_W bits, held until next start
//  Rev     : 1.0  initial release
// ============================================================================
module ise_div #(
  parameter int DVD_W = 15,
  parameter int DVS_W = 3,
  parameter int Q_W   = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int c_cnt_w = $clog2(Q_W + 1);

  logic [DVS_W-1:0]   r_rem;
  logic [Q_W-1:0]     r_q;      // remaining dividend bits shift out, quotient bits shift in
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_run;
  logic               r_done;

  logic [DVS_W:0]     w_shift;
  logic [DVS_W:0]     w_diff;
  logic               w_ge;

  assign w_shift = {r_rem, r_q[Q_W-1]};
  assign w_ge    = (w_shift >= {1'b0, divisor});
  assign w_diff  = w_shift - {1'b0, divisor};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem <= DVS_W'(dividend[DVD_W-1:Q_W]);
        r_q   <= dividend[Q_W-1:0];
        r_cnt <= c_cnt_w'(Q_W);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_rem <= w_ge ? w_diff[DVS_W-1:0] : w_shift[DVS_W-1:0];
        r_q   <= {r_q[Q_W-2:0], w_ge};
        r_cnt <= r_cnt - c_cnt_w'(1);
        if (r_cnt == c_cnt_w'(1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done     = r_done;
  assign quotient = r_q;

endmodule
`default_nettype wire

// File: rtl/ise_sorter.sv
`default_nettype none
// ============================================================================
//  Module  : ise_sorter
//  Purpose : Streams N_IMG images of PX_PER_IMG {R,G,B} pixels, classifies
//            each by dominant colour, averages the dominant channel in
//            fixed point and keeps stable-sorted per-colour lists. After the
//            last image the sorted indices stream out: R, then G, then B.
//  Ports   : clk, reset (async, active-high)
//            in_valid, image_in_index, pixel_in  - pixel stream in
//            busy                                - high: pixels not accepted
//            out_valid, color_index, image_out_index - sorted results
//  Rev     : 1.0  initial release
// ============================================================================
module ise_sorter
  import ise_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int PX_PER_IMG = 16384,
  parameter int N_IMG      = 32,
  parameter int FRAC_W     = 4,
  parameter int IDX_W      = $clog2(N_IMG)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [IDX_W-1:0]   image_in_index,
  input  logic [3*PIX_W-1:0] pixel_in,
  output logic               busy,
  output logic               out_valid,
  output logic [1:0]         color_index,
  output logic [IDX_W-1:0]   image_out_index
);

  localparam int c_cnt_w = cnt_width(PX_PER_IMG);
  localparam int c_sum_w = PIX_W + c_cnt_w;
  localparam int c_q_w   = q_width(PIX_W, FRAC_W);
  localparam int c_dvd_w = c_sum_w + FRAC_W;
  localparam int c_len_w = cnt_width(N_IMG);

  state_t             r_state;
  logic               r_busy;
  logic [c_cnt_w-1:0] r_px_cnt;
  logic [IDX_W-1:0]   r_img_idx;
  logic [IDX_W-1:0]   r_img_cnt;
  logic [c_cnt_w-1:0] r_cnt [3];
  logic [c_sum_w-1:0] r_sum [3];
  color_t             r_col;
  logic [c_dvd_w-1:0] r_dvd;
  logic [c_cnt_w-1:0] r_dvs;
  logic               r_div_start;
  logic [c_q_w-1:0]   r_avg;
  logic [IDX_W-1:0]   r_lst_idx [3][N_IMG];
  logic [c_q_w-1:0]   r_lst_avg [3][N_IMG];
  logic [c_len_w-1:0] r_len [3];
  color_t             r_out_col;
  logic [IDX_W-1:0]   r_out_ptr;

  logic               w_accept;
  color_t             w_px_class;
  logic [PIX_W-1:0]   w_px_dom;
  color_t             w_win;
  logic               w_div_done;
  logic [c_q_w-1:0]   w_div_q;
  logic [c_len_w-1:0] w_pos;
  logic [c_len_w-1:0] w_len_post [3];
  color_t             w_first_col;
  color_t             w_next_col;
  logic               w_next_ok;
  logic               w_last_in_list;

  logic [PIX_W-1:0]   w_r, w_g, w_b;
  assign w_r = pixel_in[3*PIX_W-1 -: PIX_W];
  assign w_g = pixel_in[2*PIX_W-1 -: PIX_W];
  assign w_b = pixel_in[PIX_W-1:0];

  assign w_accept   = in_valid && !r_busy && (r_state == ST_LOAD);
  assign w_px_class = pixel_class(CLS_MAX_W'(w_r), CLS_MAX_W'(w_g), CLS_MAX_W'(w_b));

  always_comb begin
    w_px_dom = w_b;
    case (w_px_class)
      COL_R:   w_px_dom = w_r;
      COL_G:   w_px_dom = w_g;
      default: w_px_dom = w_b;
    endcase
  end

  // Largest class count wins; ties resolve to the lowest colour code.
  always_comb begin
    w_win = COL_R;
    if (!(r_cnt[0] >= r_cnt[1] && r_cnt[0] >= r_cnt[2]))
      w_win = (r_cnt[1] >= r_cnt[2]) ? COL_G : COL_B;
  end

  // Lists are ascending, so entries with avg <= new form a prefix whose
  // length is the stable insertion slot.
  always_comb begin
    w_pos = '0;
    for (int i = 0; i < N_IMG; i++)
      if (c_len_w'(i) < r_len[r_col] && r_lst_avg[r_col][i] <= r_avg)
        w_pos = w_pos + c_len_w'(1);
  end

  // Scan downward so the lowest non-empty colour ends up selected.
  always_comb begin
    w_first_col = COL_R;
    w_next_col  = COL_R;
    w_next_ok   = 1'b0;
    for (int c = 0; c < 3; c++)
      w_len_post[c] = r_len[c] + ((r_col == color_t'(2'(c))) ? c_len_w'(1) : c_len_w'(0));
    for (int c = 2; c >= 0; c--) begin
      if (w_len_post[c] != '0)
        w_first_col = color_t'(2'(c));
      if (2'(c) > r_out_col && r_len[c] != '0) begin
        w_next_col = color_t'(2'(c));
        w_next_ok  = 1'b1;
      end
    end
  end

  assign w_last_in_list = ((c_len_w'(r_out_ptr) + c_len_w'(1)) == r_len[r_out_col]);

  ise_div #(
    .DVD_W (c_dvd_w),
    .DVS_W (c_cnt_w),
    .Q_W   (c_q_w)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (r_div_start),
    .dividend (r_dvd),
    .divisor  (r_dvs),
    .done     (w_div_done),
    .quotient (w_div_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b1;
      r_px_cnt    <= '0;
      r_img_idx   <= '0;
      r_img_cnt   <= '0;
      r_col       <= COL_R;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_div_start <= 1'b0;
      r_avg       <= '0;
      r_out_col   <= COL_R;
      r_out_ptr   <= '0;
      for (int c = 0; c < 3; c++) begin
        r_cnt[c] <= '0;
        r_sum[c] <= '0;
        r_len[c] <= '0;
        for (int i = 0; i < N_IMG; i++) begin
          r_lst_idx[c][i] <= '0;
          r_lst_avg[c][i] <= '0;
        end
      end
    end else begin
      r_div_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_state  <= ST_LOAD;
          r_busy   <= 1'b0;
          r_px_cnt <= '0;
          for (int c = 0; c < 3; c++) begin
            r_cnt[c] <= '0;
            r_sum[c] <= '0;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            if (r_px_cnt == '0)
              r_img_idx <= image_in_index;
            r_cnt[w_px_class] <= r_cnt[w_px_class] + c_cnt_w'(1);
            r_sum[w_px_class] <= r_sum[w_px_class] + c_sum_w'(w_px_dom);
            r_px_cnt          <= r_px_cnt + c_cnt_w'(1);
            if (r_px_cnt == c_cnt_w'(PX_PER_IMG - 1)) begin
              r_state <= ST_CLASS;
              r_busy  <= 1'b1;
            end
          end
        end
        ST_CLASS: begin
          r_col       <= w_win;
          r_dvd       <= {r_sum[w_win], {FRAC_W{1'b0}}};
          r_dvs       <= r_cnt[w_win];
          r_div_start <= 1'b1;
          r_state     <= ST_DIV;
        end
        ST_DIV: begin
          if (w_div_done) begin
            r_avg   <= w_div_q;
            r_state <= ST_INSERT;
          end
        end
        ST_INSERT: begin
          for (int i = 1; i < N_IMG; i++) begin
            if (c_len_w'(i) > w_pos && c_len_w'(i) <= r_len[r_col]) begin
              r_lst_idx[r_col][i] <= r_lst_idx[r_col][i-1];
              r_lst_avg[r_col][i] <= r_lst_avg[r_col][i-1];
            end
          end
          r_lst_idx[r_col][IDX_W'(w_pos)] <= r_img_idx;
          r_lst_avg[r_col][IDX_W'(w_pos)] <= r_avg;
          r_len[r_col] <= r_len[r_col] + c_len_w'(1);
          if (r_img_cnt == IDX_W'(N_IMG - 1)) begin
            r_img_cnt <= '0;
            r_out_col <= w_first_col;
            r_out_ptr <= '0;
            r_state   <= ST_OUT;
          end else begin
            r_img_cnt <= r_img_cnt + IDX_W'(1);
            r_state   <= ST_LOAD;
            r_busy    <= 1'b0;
            r_px_cnt  <= '0;
            for (int c = 0; c < 3; c++) begin
              r_cnt[c] <= '0;
              r_sum[c] <= '0;
            end
          end
        end
        ST_OUT: begin
          if (!w_last_in_list) begin
            r_out_ptr <= r_out_ptr + IDX_W'(1);
          end else if (w_next_ok) begin
            r_out_col <= w_next_col;
            r_out_ptr <= '0;
          end else begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          for (int c = 0; c < 3; c++) begin
            r_len[c] <= '0;
            for (int i = 0; i < N_IMG; i++) begin
              r_lst_idx[c][i] <= '0;
              r_lst_avg[c][i] <= '0;
            end
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy            = r_busy;
  assign out_valid       = (r_state == ST_OUT);
  assign color_index     = out_valid ? r_out_col : COL_IDLE;
  assign image_out_index = out_valid ? r_lst_idx[r_out_col][r_out_ptr] : '0;

endmodule
`default_nettype wire
